icache: RTL and testbench
=========================

# icache

Direct-mapped instruction cache: the responding end of the datapath's instruction-fetch request (`imemREN` / `imemaddr` in, `ihit` / `imemload` out). It sits between the pipelined datapath and the memory controller's instruction port. It serves hits combinationally in the same cycle. On a miss it issues a single-word fill (`iREN` / `iaddr`, waiting on `iwait`) and then replays the request as a hit.

## Interface
Parameters:
- SETS, 16, number of one-word frames; power of two.
- IDX_W, 4, log2(SETS); tag width is 30 - IDX_W.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  synchronous, active-high reset. Sampled on the CLK rising edge; reset is applied when the signal is 1.
- dp_imemREN  in  1  datapath fetch request.
- dp_imemaddr  in  32  byte address of the fetch; bits [1:0] are ignored.
- dp_ihit  out  1  fetch data valid this cycle.
- dp_imemload  out  32  instruction word; 0 when dp_ihit=0.
- mem_iREN  out  1  fill request to the memory controller.
- mem_iaddr  out  32  fill address, word aligned.
- mem_iwait  in  1  memory busy; fill data is valid in a cycle where mem_iREN=1 and mem_iwait=0.
- mem_iload  in  32  fill data.
- inv  in  1  invalidate all frames.
- hit_count  out  32  hit counter (see Configuration).
- miss_count  out  32  miss counter (see Configuration).

## Operation
- Address split: tag = addr[31:IDX_W+2], index = addr[IDX_W+1:2].
- Each frame holds valid, tag and data.
- Hit condition: dp_imemREN=1, frame[index].valid=1, frame[index].tag=tag, and FSM in IDLE.
- Two FSM states:
  - IDLE:
    - Hit: dp_ihit=1 and dp_imemload=frame data, combinationally.
    - Miss (dp_imemREN=1 and no hit): latch the word-aligned dp_imemaddr into fill_addr and go to FETCH.
    - No request: stay in IDLE.
  - FETCH:
    - mem_iREN=1 and mem_iaddr=fill_addr; dp_ihit=0.
    - While mem_iwait=1: stay in FETCH.
    - When mem_iwait=0: write {valid=1, tag, mem_iload} into the frame at fill_addr's index and go to IDLE.
- Outputs in IDLE: mem_iREN=0, mem_iaddr=0.
- A fill always replaces the indexed frame; there is no replacement choice.
- Redirects:
  - If dp_imemaddr changes or dp_imemREN drops during FETCH, the fill of fill_addr still completes.
  - After returning to IDLE, the new address is evaluated as a fresh request.
- inv=1:
  - All valid bits are cleared on the next edge.
  - If inv coincides with fill completion, the filled frame is also left invalid.
  - If inv arrives in FETCH, the FSM continues until the fill completes, then returns to IDLE.
  - A hit is still reported in the cycle inv is asserted; it is based on pre-invalidate state.
- Reset: all valid bits 0, FSM=IDLE, fill_addr=0, counters=0.
  - Resulting outputs: dp_ihit=0, dp_imemload=0, mem_iREN=0, mem_iaddr=0.
  - Reset in the middle of FETCH abandons the fill; mem_iREN drops the cycle after the reset edge.

## Timing
- Hit latency: 0 cycles; dp_ihit is asserted in the request cycle.
- Miss latency: dp_ihit is asserted 2+W cycles after the first request cycle, where W is the number of FETCH cycles with mem_iwait=1.
  - Cycle 0: miss detected in IDLE.
  - Cycle 1: first FETCH cycle.
  - The fill is written on the edge ending the FETCH cycle that has mem_iwait=0.
  - The next cycle is an IDLE hit.
- mem_iREN stays high for every FETCH cycle and is never asserted in IDLE.
- mem_iaddr is stable for the whole FETCH period.

## Configuration
- ICACHE_STATS_EN defined:
  - hit_count increments on every cycle with dp_ihit=1.
  - miss_count increments on every IDLE→FETCH transition.
  - Both are 32-bit and wrap modulo 2^32.
  - Both are cleared by reset only; inv does not clear them.
- ICACHE_STATS_EN undefined:
  - Both ports remain present, tied to 0; no counter registers are built.

## Structure
- Shared package cpu_types_pkg:
  - Existing word_t.
  - New icache_frame_t, a packed struct {valid, tag, data}.
  - New icachef_t address-split struct {tag, idx, bytoff}.
  - ICACHE_SETS constant (16).
- The FSM state enum (IDLE, FETCH) is local to icache.
- No sub-module: the frame array, FSM and counters live in the single module.

## Test plan
- Reset, then request 0x00000040 with mem_iwait high for 3 cycles and mem_iload=0xDEADBEEF:
  - mem_iREN high for 4 cycles with mem_iaddr=0x40.
  - dp_ihit=1 with 0xDEADBEEF 5 cycles after the request.
  - miss_count=1.
- Re-request 0x40 → dp_ihit=1 with 0xDEADBEEF the same cycle, no mem_iREN; hit_count increments.
- Conflict: fill 0x40, then request 0x80 (same index, different tag):
  - Miss and fill of 0x80.
  - A following request to 0x40 misses again.
- Redirect: during FETCH of 0x100, change dp_imemaddr to 0x104:
  - The fill of 0x100 completes.
  - Then 0x104 is fetched (mem_iaddr=0x104).
  - After that, both addresses hit.
- Coincident invalidate and fill: inv=1 in the same cycle the fill completes (mem_iwait=0) → the next request to the same address misses again.
- Reset asserted for one cycle in FETCH:
  - mem_iREN=0 the cycle after the reset edge.
  - All prior entries miss.
  - Counters read 0 when ICACHE_STATS_EN is defined, and always 0 without it.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: the machine word plus the instruction-cache frame and
// address-split layouts used by icache.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned ICACHE_SETS  = 16;
    localparam int unsigned ICACHE_IDX_W = 4;
    localparam int unsigned ICACHE_TAG_W = 30 - ICACHE_IDX_W;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with single-word fills.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module icache
    import cpu_types_pkg::*;
#(
    parameter int unsigned SETS  = ICACHE_SETS,
    parameter int unsigned IDX_W = ICACHE_IDX_W
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dp_imemREN,
    input  logic [31:0] dp_imemaddr,
    output logic        dp_ihit,
    output logic [31:0] dp_imemload,
    output logic        mem_iREN,
    output logic [31:0] mem_iaddr,
    input  logic        mem_iwait,
    input  logic [31:0] mem_iload,
    input  logic        inv,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int unsigned TAG_W = 30 - IDX_W;

    typedef enum logic {
        IDLE,
        FETCH
    } state_e;

    state_e           state_q, state_d;
    word_t            fill_addr_q, fill_addr_d;
    icache_frame_t    frames_q [SETS];
    icache_frame_t    req_frame;
    logic [IDX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic             hit;
    logic             fill_done;
    logic             unused_bytoff;

    assign req_idx       = dp_imemaddr[IDX_W+1:2];
    assign req_tag       = dp_imemaddr[31:IDX_W+2];
    assign fill_idx      = fill_addr_q[IDX_W+1:2];
    assign fill_tag      = fill_addr_q[31:IDX_W+2];
    assign req_frame     = frames_q[req_idx];
    assign unused_bytoff = ^dp_imemaddr[1:0];

    assign hit = dp_imemREN && (state_q == IDLE) && req_frame.valid
                 && (req_frame.tag == req_tag);

    always_comb begin
        state_d     = state_q;
        fill_addr_d = fill_addr_q;
        dp_ihit     = 1'b0;
        dp_imemload = '0;
        mem_iREN    = 1'b0;
        mem_iaddr   = '0;
        fill_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    dp_ihit     = 1'b1;
                    dp_imemload = req_frame.data;
                end else if (dp_imemREN) begin
                    state_d     = FETCH;
                    fill_addr_d = {dp_imemaddr[31:2], 2'b00};
                end
            end
            FETCH: begin
                mem_iREN  = 1'b1;
                mem_iaddr = fill_addr_q;
                if (!mem_iwait) begin
                    fill_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The invalidate sweep follows the fill write so a coincident inv leaves the new frame invalid.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q     <= IDLE;
            fill_addr_q <= '0;
            frames_q    <= '{default: '0};
        end else begin
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
            if (fill_done) begin
                frames_q[fill_idx] <= '{valid: 1'b1, tag: fill_tag, data: mem_iload};
            end
            if (inv) begin
                for (int unsigned i = 0; i < SETS; i++) begin
                    frames_q[i[IDX_W-1:0]].valid <= 1'b0;
                end
            end
        end
    end

`ifdef ICACHE_STATS_EN
    word_t hit_cnt_q, miss_cnt_q;
    logic  miss_start;

    assign miss_start = (state_q == IDLE) && (state_d == FETCH);

    always_ff @(posedge CLK) begin
        if (nRST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (dp_ihit)    hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a line-address cache model.
module tb_icache;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dp_imemREN;
    logic [31:0] dp_imemaddr;
    logic        dp_ihit;
    logic [31:0] dp_imemload;
    logic        mem_iREN;
    logic [31:0] mem_iaddr;
    logic        mem_iwait;
    logic [31:0] mem_iload;
    logic        inv;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

`ifdef ICACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    icache #(.SETS(16), .IDX_W(4)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .dp_imemREN (dp_imemREN),
        .dp_imemaddr(dp_imemaddr),
        .dp_ihit    (dp_ihit),
        .dp_imemload(dp_imemload),
        .mem_iREN   (mem_iREN),
        .mem_iaddr  (mem_iaddr),
        .mem_iwait  (mem_iwait),
        .mem_iload  (mem_iload),
        .inv        (inv),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int unsigned v);
        return STATS ? 32'(v) : 32'd0;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: each index remembers which word address it holds.
    bit          m_valid [16];
    logic [29:0] m_line  [16];
    logic [31:0] m_data  [16];
    bit          m_busy;
    bit          m_ready = 1'b0;
    logic [31:0] m_faddr;
    int unsigned m_hits, m_miss;
    logic [3:0]  m_idx, m_fidx;
    bit          m_ehit;

    initial begin
        forever begin
            @(negedge CLK);
            m_idx  = dp_imemaddr[5:2];
            m_ehit = dp_imemREN && !m_busy && m_valid[m_idx]
                     && (m_line[m_idx] == dp_imemaddr[31:2]);
            if (m_ready) begin
                chk("m_ihit",  32'(dp_ihit), 32'(m_ehit));
                chk("m_load",  dp_imemload, m_ehit ? m_data[m_idx] : 32'd0);
                chk("m_iREN",  32'(mem_iREN), 32'(m_busy));
                chk("m_iaddr", mem_iaddr, m_busy ? m_faddr : 32'd0);
                chk("m_hitcnt",  hit_count,  exp_cnt(m_hits));
                chk("m_misscnt", miss_count, exp_cnt(m_miss));
            end
            @(posedge CLK);
            if (nRST) begin
                foreach (m_valid[i]) m_valid[i] = 1'b0;
                m_busy  = 1'b0;
                m_faddr = '0;
                m_hits  = 0;
                m_miss  = 0;
                m_ready = 1'b1;
            end else if (m_ready) begin
                if (m_busy && !mem_iwait) begin
                    m_fidx         = m_faddr[5:2];
                    m_valid[m_fidx] = 1'b1;
                    m_line[m_fidx]  = m_faddr[31:2];
                    m_data[m_fidx]  = mem_iload;
                    m_busy          = 1'b0;
                end else if (!m_busy && dp_imemREN && !m_ehit) begin
                    m_busy  = 1'b1;
                    m_faddr = dp_imemaddr & 32'hFFFF_FFFC;
                    m_miss++;
                end
                if (m_ehit) m_hits++;
                if (inv) foreach (m_valid[i]) m_valid[i] = 1'b0;
            end
        end
    end

    // Plain miss with zero wait states: miss, one FETCH cycle, then a hit.
    task automatic fetch_miss(input logic [31:0] addr, input logic [31:0] data);
        dp_imemREN  = 1'b1;
        dp_imemaddr = addr;
        mem_iwait   = 1'b0;
        mem_iload   = data;
        @(negedge CLK);
        chk("fm_miss", 32'(dp_ihit), 32'd0);
        step();
        @(negedge CLK);
        chk("fm_iREN", 32'(mem_iREN), 32'd1);
        chk("fm_iaddr", mem_iaddr, addr);
        step();
        @(negedge CLK);
        chk("fm_hit", 32'(dp_ihit), 32'd1);
        chk("fm_load", dp_imemload, data);
        step();
        dp_imemREN = 1'b0;
    endtask

    int unsigned ren_cnt;

    initial begin
        nRST        = 1'b1;
        dp_imemREN  = 1'b0;
        dp_imemaddr = '0;
        inv         = 1'b0;
        mem_iwait   = 1'b0;
        mem_iload   = '0;
        step();
        step();
        nRST = 1'b0;
        @(negedge CLK);
        chk("rst_ihit",  32'(dp_ihit), 32'd0);
        chk("rst_load",  dp_imemload, 32'd0);
        chk("rst_iREN",  32'(mem_iREN), 32'd0);
        chk("rst_iaddr", mem_iaddr, 32'd0);
        chk("rst_hitcnt",  hit_count, 32'd0);
        chk("rst_misscnt", miss_count, 32'd0);
        step();

        // Miss on 0x40 with three wait cycles.
        ren_cnt     = 0;
        dp_imemREN  = 1'b1;
        dp_imemaddr = 32'h40;
        mem_iload   = 32'hDEADBEEF;
        for (int c = 0; c <= 5; c++) begin
            mem_iwait = (c >= 1 && c <= 3);
            @(negedge CLK);
            if (mem_iREN) begin
                ren_cnt++;
                chk("A_iaddr", mem_iaddr, 32'h40);
            end
            if (c == 5) begin
                chk("A_hit",  32'(dp_ihit), 32'd1);
                chk("A_load", dp_imemload, 32'hDEADBEEF);
                chk("A_misscnt", miss_count, exp_cnt(1));
            end else begin
                chk("A_nohit", 32'(dp_ihit), 32'd0);
            end
            step();
        end
        chk("A_iREN_cycles", ren_cnt, 32'd4);
        @(negedge CLK);
        chk("A_rehit",  32'(dp_ihit), 32'd1);
        chk("A_reload", dp_imemload, 32'hDEADBEEF);
        chk("A_noREN",  32'(mem_iREN), 32'd0);
        chk("A_hitcnt1", hit_count, exp_cnt(1));
        step();
        dp_imemREN = 1'b0;
        @(negedge CLK);
        chk("A_hitcnt2", hit_count, exp_cnt(2));
        chk("A_idle_load", dp_imemload, 32'd0);
        step();

        // Conflict on index 0.
        fetch_miss(32'h80, 32'h1111_2222);
        fetch_miss(32'h40, 32'h3333_4444);

        // Redirect during FETCH.
        dp_imemREN  = 1'b1;
        dp_imemaddr = 32'h100;
        mem_iwait   = 1'b0;
        mem_iload   = 32'hC0DE_0100;
        @(negedge CLK);
        chk("C_miss", 32'(dp_ihit), 32'd0);
        step();
        dp_imemaddr = 32'h104;
        @(negedge CLK);
        chk("C_iaddr0", mem_iaddr, 32'h100);
        chk("C_nohit",  32'(dp_ihit), 32'd0);
        step();
        mem_iload = 32'hC0DE_0104;
        @(negedge CLK);
        chk("C_miss2", 32'(dp_ihit), 32'd0);
        chk("C_idle",  32'(mem_iREN), 32'd0);
        step();
        @(negedge CLK);
        chk("C_iaddr1", mem_iaddr, 32'h104);
        step();
        @(negedge CLK);
        chk("C_hit104",  32'(dp_ihit), 32'd1);
        chk("C_load104", dp_imemload, 32'hC0DE_0104);
        step();
        dp_imemaddr = 32'h100;
        @(negedge CLK);
        chk("C_hit100",  32'(dp_ihit), 32'd1);
        chk("C_load100", dp_imemload, 32'hC0DE_0100);
        step();
        dp_imemREN = 1'b0;

        // Invalidate coinciding with fill completion.
        dp_imemREN  = 1'b1;
        dp_imemaddr = 32'h200;
        mem_iload   = 32'hD00D_0200;
        @(negedge CLK);
        chk("D_miss", 32'(dp_ihit), 32'd0);
        step();
        inv = 1'b1;
        @(negedge CLK);
        chk("D_iREN", 32'(mem_iREN), 32'd1);
        step();
        inv = 1'b0;
        @(negedge CLK);
        chk("D_remiss", 32'(dp_ihit), 32'd0);
        step();
        @(negedge CLK);
        chk("D_refetch", mem_iaddr, 32'h200);
        step();
        @(negedge CLK);
        chk("D_hit", dp_imemload, 32'hD00D_0200);
        step();
        dp_imemREN = 1'b0;

        // Reset in the middle of a fill.
        dp_imemREN  = 1'b1;
        dp_imemaddr = 32'h300;
        mem_iwait   = 1'b1;
        @(negedge CLK);
        chk("E_miss", 32'(dp_ihit), 32'd0);
        step();
        nRST = 1'b1;
        @(negedge CLK);
        chk("E_iREN", 32'(mem_iREN), 32'd1);
        step();
        nRST       = 1'b0;
        dp_imemREN = 1'b0;
        mem_iwait  = 1'b0;
        @(negedge CLK);
        chk("E_iREN_drop", 32'(mem_iREN), 32'd0);
        chk("E_hitcnt",  hit_count, 32'd0);
        chk("E_misscnt", miss_count, 32'd0);
        step();
        fetch_miss(32'h104, 32'hE000_0104);

        // Randomized traffic checked by the model.
        for (int i = 0; i < 4000; i++) begin
            nRST        = ($urandom_range(0, 199) == 0);
            dp_imemREN  = ($urandom_range(0, 3) != 0);
            dp_imemaddr = ($urandom_range(0, 127) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) dp_imemaddr = dp_imemaddr | 32'hABC0_0000;
            mem_iwait   = ($urandom_range(0, 2) == 0);
            inv         = ($urandom_range(0, 49) == 0);
            mem_iload   = $urandom;
            step();
        end
        nRST       = 1'b0;
        dp_imemREN = 1'b0;
        inv        = 1'b0;
        mem_iwait  = 1'b0;
        step();
        step();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
